// File: rtl/exec_unit.sv
// exec_unit: cpu15-family execute stage (ALU, load/store, branches, Z/C/N flags).
// Latency: single-cycle ops register results one CLK_EX edge after the opcode; MUL takes DATA_W+1 edges.
// Backpressure: BUSY stalls fetch during MUL (only when EXEC_MUL_EN is defined; otherwise BUSY is tied 0).
module exec_unit #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
) (
  input  logic              CLK_EX,
  input  logic              RESET_N,
  input  logic [4:0]        OP_CODE,
  input  logic [DATA_W-1:0] REG_A,
  input  logic [DATA_W-1:0] REG_B,
  input  logic [DATA_W/2-1:0] OP_DATA,
  input  logic [DATA_W-1:0] RAM_OUT,
  output logic [PC_W-1:0]   P_COUNT,
  output logic [DATA_W-1:0] REG_IN,
  output logic [DATA_W-1:0] RAM_IN,
  output logic              REG_WEN,
  output logic              RAM_WEN,
  output logic              BUSY,
  output logic [2:0]        FLAGS
);

  localparam int HALF = DATA_W / 2;

  localparam logic [4:0] OP_MOV = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_AND = 5'h03;
  localparam logic [4:0] OP_OR  = 5'h04;
  localparam logic [4:0] OP_SL  = 5'h05;
  localparam logic [4:0] OP_SR  = 5'h06;
  localparam logic [4:0] OP_SRA = 5'h07;
  localparam logic [4:0] OP_LDL = 5'h08;
  localparam logic [4:0] OP_LDH = 5'h09;
  localparam logic [4:0] OP_CMP = 5'h0A;
  localparam logic [4:0] OP_JE  = 5'h0B;
  localparam logic [4:0] OP_JMP = 5'h0C;
  localparam logic [4:0] OP_LD  = 5'h0D;
  localparam logic [4:0] OP_ST  = 5'h0E;
  localparam logic [4:0] OP_HLT = 5'h0F;
  localparam logic [4:0] OP_JNE = 5'h11;
  localparam logic [4:0] OP_JC  = 5'h12;
  localparam logic [4:0] OP_JN  = 5'h13;

  // Flag bit positions within FLAGS = {N, C, Z}
  localparam int FZ = 0;
  localparam int FC = 1;
  localparam int FN = 2;

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   target;
  logic [DATA_W-1:0] n_reg_in;
  logic [DATA_W-1:0] n_ram_in;
  logic              n_reg_wen;
  logic              n_ram_wen;
  logic [PC_W-1:0]   n_pc;
  logic [2:0]        n_flags;

`ifdef EXEC_MUL_EN
  localparam logic [4:0] OP_MUL = 5'h10;
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

  state_t            state;
  logic              mul_start;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] acc;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mul_step;

  // One LSB-first shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign mul_step = acc + (mul_b[0] ? mul_a : '0);
`else
  assign BUSY = 1'b0;
`endif

  assign sum    = {1'b0, REG_A} + {1'b0, REG_B};
  assign diff   = {1'b0, REG_A} - {1'b0, REG_B};
  assign pc_inc = P_COUNT + PC_W'(1);
  assign target = OP_DATA[PC_W-1:0];

  // Decode the presented opcode into next-state values for a single-cycle instruction
  always_comb begin
    n_reg_in  = REG_IN;
    n_ram_in  = RAM_IN;
    n_reg_wen = 1'b0;
    n_ram_wen = 1'b0;
    n_pc      = pc_inc;
    n_flags   = FLAGS;
`ifdef EXEC_MUL_EN
    mul_start = 1'b0;
`endif
    case (OP_CODE)
      OP_MOV: begin n_reg_in = REG_B; n_reg_wen = 1'b1; end
      OP_ADD: begin
        n_reg_in  = sum[DATA_W-1:0];
        n_reg_wen = 1'b1;
        n_flags   = {sum[DATA_W-1], sum[DATA_W], (sum[DATA_W-1:0] == '0)};
      end
      OP_SUB: begin
        n_reg_in  = diff[DATA_W-1:0];
        n_reg_wen = 1'b1;
        n_flags   = {diff[DATA_W-1], diff[DATA_W], (diff[DATA_W-1:0] == '0)};
      end
      OP_AND: begin n_reg_in = REG_A & REG_B; n_reg_wen = 1'b1; end
      OP_OR:  begin n_reg_in = REG_A | REG_B; n_reg_wen = 1'b1; end
      OP_SL:  begin n_reg_in = {REG_A[DATA_W-2:0], 1'b0}; n_reg_wen = 1'b1; end
      OP_SR:  begin n_reg_in = {1'b0, REG_A[DATA_W-1:1]}; n_reg_wen = 1'b1; end
      OP_SRA: begin n_reg_in = {REG_A[DATA_W-1], REG_A[DATA_W-1:1]}; n_reg_wen = 1'b1; end
      OP_LDL: begin n_reg_in = {REG_A[DATA_W-1:HALF], OP_DATA}; n_reg_wen = 1'b1; end
      OP_LDH: begin n_reg_in = {OP_DATA, REG_A[HALF-1:0]}; n_reg_wen = 1'b1; end
      // Borrow out of the widened subtract is the unsigned A<B condition
      OP_CMP: n_flags = {diff[DATA_W-1], diff[DATA_W], (diff[DATA_W-1:0] == '0)};
      OP_JE:  if (FLAGS[FZ]) n_pc = target;
      OP_JMP: n_pc = target;
      OP_LD:  begin n_reg_in = RAM_OUT; n_reg_wen = 1'b1; end
      OP_ST:  begin n_ram_in = REG_A; n_ram_wen = 1'b1; end
      // Holding PC makes fetch keep returning HLT, so the core stays parked
      OP_HLT: n_pc = P_COUNT;
      OP_JNE: if (!FLAGS[FZ]) n_pc = target;
      OP_JC:  if (FLAGS[FC]) n_pc = target;
      OP_JN:  if (FLAGS[FN]) n_pc = target;
`ifdef EXEC_MUL_EN
      OP_MUL: begin mul_start = 1'b1; n_pc = P_COUNT; end
`endif
      default: ; // NOP: PC+1, no writes
    endcase
  end

  // Register all outputs; the multiplier FSM, when present, takes priority over single-cycle decode
  always_ff @(posedge CLK_EX or negedge RESET_N) begin
    if (!RESET_N) begin
      P_COUNT <= '0;
      REG_IN  <= '0;
      RAM_IN  <= '0;
      REG_WEN <= 1'b0;
      RAM_WEN <= 1'b0;
      FLAGS   <= '0;
`ifdef EXEC_MUL_EN
      BUSY    <= 1'b0;
      state   <= S_IDLE;
      mul_a   <= '0;
      mul_b   <= '0;
      acc     <= '0;
      cnt     <= '0;
`endif
    end
`ifdef EXEC_MUL_EN
    else if (state == S_MUL) begin
      // OP_CODE is ignored here; operands were latched on the accept edge
      acc     <= mul_step;
      mul_a   <= {mul_a[DATA_W-2:0], 1'b0};
      mul_b   <= {1'b0, mul_b[DATA_W-1:1]};
      cnt     <= cnt - CW'(1);
      REG_WEN <= 1'b0;
      RAM_WEN <= 1'b0;
      if (cnt == CW'(1)) begin
        REG_IN  <= mul_step;
        REG_WEN <= 1'b1;
        P_COUNT <= pc_inc;
        BUSY    <= 1'b0;
        state   <= S_IDLE;
      end
    end
    else if (mul_start) begin
      mul_a   <= REG_A;
      mul_b   <= REG_B;
      acc     <= '0;
      cnt     <= CW'(DATA_W);
      BUSY    <= 1'b1;
      REG_WEN <= 1'b0;
      RAM_WEN <= 1'b0;
      state   <= S_MUL;
    end
`endif
    else begin
      P_COUNT <= n_pc;
      REG_IN  <= n_reg_in;
      RAM_IN  <= n_ram_in;
      REG_WEN <= n_reg_wen;
      RAM_WEN <= n_ram_wen;
      FLAGS   <= n_flags;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed testbench for exec_unit at DATA_W=16, PC_W=8.
// Inputs are driven after each rising edge and outputs sampled 1ns after it.
// The MUL scenarios follow whichever EXEC_MUL_EN build is compiled.
module tb_exec_unit;

  localparam logic [4:0] MOV = 5'h00, ADD = 5'h01, SUB = 5'h02, AND_ = 5'h03, OR_ = 5'h04;
  localparam logic [4:0] SL = 5'h05, SR = 5'h06, SRA = 5'h07, LDL = 5'h08, LDH = 5'h09;
  localparam logic [4:0] CMP = 5'h0A, JE = 5'h0B, JMP = 5'h0C, LD = 5'h0D, ST = 5'h0E;
  localparam logic [4:0] HLT = 5'h0F, MUL = 5'h10, JNE = 5'h11, JC = 5'h12, JN = 5'h13;
  localparam logic [4:0] NOP = 5'h14;

  logic        CLK_EX;
  logic        RESET_N;
  logic [4:0]  OP_CODE;
  logic [15:0] REG_A, REG_B, RAM_OUT;
  logic [7:0]  OP_DATA;
  logic [7:0]  P_COUNT;
  logic [15:0] REG_IN, RAM_IN;
  logic        REG_WEN, RAM_WEN, BUSY;
  logic [2:0]  FLAGS;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_pc;

  exec_unit #(.DATA_W(16), .PC_W(8)) dut (
    .CLK_EX(CLK_EX), .RESET_N(RESET_N), .OP_CODE(OP_CODE), .REG_A(REG_A), .REG_B(REG_B),
    .OP_DATA(OP_DATA), .RAM_OUT(RAM_OUT), .P_COUNT(P_COUNT), .REG_IN(REG_IN), .RAM_IN(RAM_IN),
    .REG_WEN(REG_WEN), .RAM_WEN(RAM_WEN), .BUSY(BUSY), .FLAGS(FLAGS)
  );

  initial begin
    CLK_EX = 1'b0;
    forever #5 CLK_EX = ~CLK_EX;
  end

  // Present one instruction and advance to 1ns past the edge that executes it
  task automatic drive(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input logic [7:0] d);
    OP_CODE = op; REG_A = a; REG_B = b; OP_DATA = d;
    @(posedge CLK_EX); #1;
  endtask

  task automatic test_reset;
    RESET_N = 1'b1; OP_CODE = NOP; REG_A = '0; REG_B = '0; OP_DATA = '0; RAM_OUT = 16'h7E81;
    #2 RESET_N = 1'b0;
    #1;
    checks++; if (P_COUNT !== 8'h00) begin errors++; $display("FAIL rst_pc got %h want 00", P_COUNT); end
    checks++; if (REG_IN !== 16'h0000) begin errors++; $display("FAIL rst_reg_in got %h want 0000", REG_IN); end
    checks++; if (RAM_IN !== 16'h0000) begin errors++; $display("FAIL rst_ram_in got %h want 0000", RAM_IN); end
    checks++; if ({REG_WEN, RAM_WEN, BUSY} !== 3'b000) begin errors++; $display("FAIL rst_strobes got %b want 000", {REG_WEN, RAM_WEN, BUSY}); end
    checks++; if (FLAGS !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", FLAGS); end
    @(negedge CLK_EX) RESET_N = 1'b1;
    // Build up non-zero state, then pulse reset between edges
    drive(NOP, 16'h0, 16'h0, 8'h0);
    drive(NOP, 16'h0, 16'h0, 8'h0);
    drive(SUB, 16'd5, 16'd7, 8'h0);
    drive(ST, 16'hBEEF, 16'h0, 8'h0);
    drive(MOV, 16'h0, 16'h1234, 8'h0);
    checks++; if ({P_COUNT, REG_IN, RAM_IN} !== {8'h05, 16'h1234, 16'hBEEF}) begin errors++; $display("FAIL pre_reset got %h %h %h want 05 1234 beef", P_COUNT, REG_IN, RAM_IN); end
    checks++; if ({FLAGS, REG_WEN, RAM_WEN} !== 5'b110_1_0) begin errors++; $display("FAIL pre_reset_flags got %b want 11010", {FLAGS, REG_WEN, RAM_WEN}); end
    #3 RESET_N = 1'b0;
    #1;
    checks++; if ({P_COUNT, REG_IN, RAM_IN} !== 40'h0) begin errors++; $display("FAIL midcycle_rst got %h %h %h want 0", P_COUNT, REG_IN, RAM_IN); end
    checks++; if ({FLAGS, REG_WEN, RAM_WEN, BUSY} !== 6'b0) begin errors++; $display("FAIL midcycle_rst_ctl got %b want 000000", {FLAGS, REG_WEN, RAM_WEN, BUSY}); end
    #2 RESET_N = 1'b1;
    exp_pc = 8'h00;
  endtask

  task automatic test_add;
    drive(ADD, 16'hFFFF, 16'h0001, 8'h0);
    checks++; if ({REG_IN, REG_WEN} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL add_wrap got %h/%b want 0000/1", REG_IN, REG_WEN); end
    checks++; if (FLAGS !== 3'b011) begin errors++; $display("FAIL add_flags got %b want 011", FLAGS); end
    checks++; if (P_COUNT !== 8'h01) begin errors++; $display("FAIL add_pc got %h want 01", P_COUNT); end
    exp_pc = 8'h01;
  endtask

  task automatic test_alu;
    logic [4:0]  ops [9];
    logic [15:0] res [9];
    ops = '{MOV, AND_, OR_, SL, SR, SRA, LDL, LDH, LD};
    res = '{16'h0F31, 16'h0A10, 16'h8F7D, 16'h14B8, 16'h452E, 16'hC52E, 16'h8A3C, 16'h3C5C, 16'h7E81};
    drive(ADD, 16'h8A5C, 16'h0F31, 8'h3C); exp_pc++;
    checks++; if ({REG_IN, FLAGS} !== {16'h998D, 3'b100}) begin errors++; $display("FAIL add2 got %h/%b want 998d/100", REG_IN, FLAGS); end
    for (int i = 0; i < 9; i++) begin
      drive(ops[i], 16'h8A5C, 16'h0F31, 8'h3C); exp_pc++;
      checks++;
      if ({REG_IN, REG_WEN, RAM_WEN, FLAGS, P_COUNT} !== {res[i], 1'b1, 1'b0, 3'b100, exp_pc}) begin
        errors++; $display("FAIL alu_op%0h got %h wen%b%b fl%b pc%h want %h wen10 fl100 pc%h", ops[i], REG_IN, REG_WEN, RAM_WEN, FLAGS, P_COUNT, res[i], exp_pc);
      end
    end
    drive(SUB, 16'h1000, 16'h0001, 8'h0); exp_pc++;
    checks++; if ({REG_IN, FLAGS} !== {16'h0FFF, 3'b000}) begin errors++; $display("FAIL sub got %h/%b want 0fff/000", REG_IN, FLAGS); end
    drive(ST, 16'h5A5A, 16'h1111, 8'h0); exp_pc++;
    checks++; if ({RAM_IN, RAM_WEN, REG_WEN, REG_IN} !== {16'h5A5A, 1'b1, 1'b0, 16'h0FFF}) begin errors++; $display("FAIL st got %h %b%b %h want 5a5a 10 0fff", RAM_IN, RAM_WEN, REG_WEN, REG_IN); end
    drive(CMP, 16'd3, 16'd3, 8'h0); exp_pc++;
    checks++; if ({FLAGS, REG_WEN, RAM_WEN, REG_IN, RAM_IN} !== {3'b001, 2'b00, 16'h0FFF, 16'h5A5A}) begin errors++; $display("FAIL cmp_eq got %b %b%b %h %h want 001 00 0fff 5a5a", FLAGS, REG_WEN, RAM_WEN, REG_IN, RAM_IN); end
    checks++; if (P_COUNT !== exp_pc) begin errors++; $display("FAIL alu_pc got %h want %h", P_COUNT, exp_pc); end
  endtask

  task automatic test_jumps;
    drive(CMP, 16'd5, 16'd7, 8'h0); exp_pc++;
    checks++; if (FLAGS !== 3'b110) begin errors++; $display("FAIL cmp_lt got %b want 110", FLAGS); end
    drive(JC, 16'h0, 16'h0, 8'h40);
    checks++; if (P_COUNT !== 8'h40) begin errors++; $display("FAIL jc_taken got %h want 40", P_COUNT); end
    drive(CMP, 16'd5, 16'd5, 8'h0);
    drive(JNE, 16'h0, 16'h0, 8'h20);
    checks++; if (P_COUNT !== 8'h42) begin errors++; $display("FAIL jne_not_taken got %h want 42", P_COUNT); end
    drive(JE, 16'h0, 16'h0, 8'h10);
    checks++; if (P_COUNT !== 8'h10) begin errors++; $display("FAIL je_taken got %h want 10", P_COUNT); end
    drive(JN, 16'h0, 16'h0, 8'h33);
    checks++; if (P_COUNT !== 8'h11) begin errors++; $display("FAIL jn_not_taken got %h want 11", P_COUNT); end
    drive(JC, 16'h0, 16'h0, 8'h55);
    checks++; if ({P_COUNT, REG_WEN, RAM_WEN} !== {8'h12, 2'b00}) begin errors++; $display("FAIL jc_not_taken got %h %b%b want 12 00", P_COUNT, REG_WEN, RAM_WEN); end
    drive(CMP, 16'd1, 16'd2, 8'h0);
    drive(JN, 16'h0, 16'h0, 8'h66);
    checks++; if (P_COUNT !== 8'h66) begin errors++; $display("FAIL jn_taken got %h want 66", P_COUNT); end
    drive(JNE, 16'h0, 16'h0, 8'h2A);
    checks++; if (P_COUNT !== 8'h2A) begin errors++; $display("FAIL jne_taken got %h want 2a", P_COUNT); end
    drive(JMP, 16'h0, 16'h0, 8'h7F);
    checks++; if (P_COUNT !== 8'h7F) begin errors++; $display("FAIL jmp got %h want 7f", P_COUNT); end
  endtask

  task automatic test_wrap;
    drive(JMP, 16'h0, 16'h0, 8'hFF);
    drive(OR_, 16'h0001, 16'h0002, 8'h0);
    checks++; if ({P_COUNT, REG_IN, REG_WEN} !== {8'h00, 16'h0003, 1'b1}) begin errors++; $display("FAIL pc_wrap got %h %h %b want 00 0003 1", P_COUNT, REG_IN, REG_WEN); end
    exp_pc = 8'h00;
  endtask

  task automatic test_nop;
    drive(NOP, 16'hAAAA, 16'h5555, 8'h12); exp_pc++;
    checks++; if ({P_COUNT, REG_WEN, RAM_WEN, REG_IN} !== {exp_pc, 2'b00, 16'h0003}) begin errors++; $display("FAIL nop14 got %h %b%b %h want %h 00 0003", P_COUNT, REG_WEN, RAM_WEN, REG_IN, exp_pc); end
    drive(5'h1F, 16'hAAAA, 16'h5555, 8'h12); exp_pc++;
    checks++; if ({P_COUNT, REG_WEN, RAM_WEN, FLAGS} !== {exp_pc, 2'b00, 3'b110}) begin errors++; $display("FAIL nop1f got %h %b%b %b want %h 00 110", P_COUNT, REG_WEN, RAM_WEN, FLAGS, exp_pc); end
  endtask

`ifdef EXEC_MUL_EN
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] prod, input string name);
    int busy_edges;
    int early_wen;
    busy_edges = 0; early_wen = 0;
    drive(MUL, a, b, 8'h0);
    checks++; if ({BUSY, REG_WEN, P_COUNT} !== {2'b10, exp_pc}) begin errors++; $display("FAIL %s_accept got %b%b %h want 10 %h", name, BUSY, REG_WEN, P_COUNT, exp_pc); end
    if (BUSY === 1'b1) busy_edges++;
    // Scramble operands: the multiplier must use the values latched at accept
    REG_A = 16'hDEAD; REG_B = 16'hBEEF;
    for (int e = 2; e <= 16; e++) begin
      @(posedge CLK_EX); #1;
      if (BUSY === 1'b1) busy_edges++;
      if (REG_WEN !== 1'b0 || P_COUNT !== exp_pc) early_wen++;
    end
    @(posedge CLK_EX); #1; exp_pc++;
    checks++; if (busy_edges !== 16) begin errors++; $display("FAIL %s_busy_edges got %0d want 16", name, busy_edges); end
    checks++; if (early_wen !== 0) begin errors++; $display("FAIL %s_early_activity got %0d want 0", name, early_wen); end
    checks++; if ({BUSY, REG_WEN, REG_IN, P_COUNT} !== {2'b01, prod, exp_pc}) begin errors++; $display("FAIL %s_result got %b%b %h %h want 01 %h %h", name, BUSY, REG_WEN, REG_IN, P_COUNT, prod, exp_pc); end
    drive(NOP, 16'h0, 16'h0, 8'h0); exp_pc++;
    checks++; if ({BUSY, REG_WEN, P_COUNT} !== {2'b00, exp_pc}) begin errors++; $display("FAIL %s_after got %b%b %h want 00 %h", name, BUSY, REG_WEN, P_COUNT, exp_pc); end
  endtask

  task automatic test_mul;
    run_mul(16'h0123, 16'h0010, 16'h1230, "mul_a");
    run_mul(16'hFFFF, 16'hFFFF, 16'h0001, "mul_b");
  endtask

  task automatic test_mul_reset;
    int wen_seen;
    wen_seen = 0;
    drive(MUL, 16'h0003, 16'h0005, 8'h0);
    for (int e = 0; e < 4; e++) begin @(posedge CLK_EX); #1; end
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL mulrst_busy_before got %b want 1", BUSY); end
    #3 RESET_N = 1'b0;
    #1;
    checks++; if ({BUSY, REG_WEN, P_COUNT} !== {2'b00, 8'h00}) begin errors++; $display("FAIL mulrst_abort got %b%b %h want 00 00", BUSY, REG_WEN, P_COUNT); end
    OP_CODE = NOP;
    @(negedge CLK_EX) RESET_N = 1'b1;
    for (int e = 0; e < 20; e++) begin
      drive(NOP, 16'h0, 16'h0, 8'h0);
      if (REG_WEN !== 1'b0 || BUSY !== 1'b0) wen_seen++;
    end
    checks++; if (wen_seen !== 0) begin errors++; $display("FAIL mulrst_stray got %0d want 0", wen_seen); end
    checks++; if (P_COUNT !== 8'd20) begin errors++; $display("FAIL mulrst_pc got %h want 14", P_COUNT); end
    exp_pc = 8'd20;
  endtask
`else
  task automatic test_mul;
    drive(MUL, 16'h0123, 16'h0010, 8'h0); exp_pc++;
    checks++; if ({P_COUNT, BUSY, REG_WEN, RAM_WEN, REG_IN} !== {exp_pc, 3'b000, 16'h0003}) begin errors++; $display("FAIL mul_nop got %h %b%b%b %h want %h 000 0003", P_COUNT, BUSY, REG_WEN, RAM_WEN, REG_IN, exp_pc); end
    drive(NOP, 16'h0, 16'h0, 8'h0); exp_pc++;
    checks++; if ({P_COUNT, BUSY} !== {exp_pc, 1'b0}) begin errors++; $display("FAIL mul_nop_next got %h %b want %h 0", P_COUNT, BUSY, exp_pc); end
  endtask
`endif

  task automatic test_hlt;
    drive(HLT, 16'h1, 16'h2, 8'h0);
    for (int e = 0; e < 10; e++) begin
      checks++;
      if ({P_COUNT, REG_WEN, RAM_WEN} !== {exp_pc, 2'b00}) begin
        errors++; $display("FAIL hlt_edge%0d got %h %b%b want %h 00", e, P_COUNT, REG_WEN, RAM_WEN, exp_pc);
      end
      if (e < 9) drive(HLT, 16'h1, 16'h2, 8'h0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu();
    test_jumps();
    test_wrap();
    test_nop();
    test_mul();
`ifdef EXEC_MUL_EN
    test_mul_reset();
`endif
    test_hlt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised execute stage for the cpu15 core family. It decodes the 5-bit opcode, performs ALU, load/store and branch operations, and drives program counter, register-file write and RAM write strobes. Compared with the fixed 16-bit stage it adds configurable data and PC widths, a Z/C/N flag register, extra conditional jumps, and an optional multi-cycle multiplier with a BUSY stall output. It sits between the register-file/RAM read stage and the writeback stage.

## Interface
- DATA_W, 16, datapath width; even, ≥8
- PC_W, 8, program counter width; must be ≤ DATA_W/2
- CLK_EX  in  1  execute clock, rising edge
- RESET_N  in  1  reset; asynchronous, active-low
- OP_CODE  in  5  opcode; must be held stable while BUSY=1
- REG_A, REG_B  in  DATA_W  register operands
- OP_DATA  in  DATA_W/2  immediate; low PC_W bits are the jump target
- RAM_OUT  in  DATA_W  RAM read data
- P_COUNT  out  PC_W  program counter
- REG_IN  out  DATA_W  register writeback data
- RAM_IN  out  DATA_W  RAM write data
- REG_WEN, RAM_WEN  out  1  write strobes
- BUSY  out  1  multi-cycle operation in progress; fetch must stall
- FLAGS  out  3  {N, C, Z}

## Operation
- Opcodes 0x00–0x0F: MOV, ADD, SUB, AND, OR, SL, SR, SRA, LDL, LDH, CMP, JE, JMP, LD, ST, HLT. Semantics are those of the cpu15 ISA, widened to DATA_W. LDL/LDH replace the low/high half of REG_A with OP_DATA.
- 0x10 MUL: REG_IN = low DATA_W bits of REG_A×REG_B, unsigned. 0x11 JNE: jump if Z=0. 0x12 JC: jump if C=1. 0x13 JN: jump if N=1. 0x14–0x1F: NOP; PC+1, both WEN 0.
- Flags:
  - ADD: Z=(sum==0), C=carry out, N=sum MSB.
  - SUB and CMP: compute A−B; Z=(diff==0), C=borrow (A<B unsigned), N=diff MSB. CMP writes no register.
  - All other opcodes leave the flags unchanged.
- Jumps: taken → P_COUNT=OP_DATA[PC_W-1:0]; not taken → P_COUNT+1. JMP is always taken.
- P_COUNT arithmetic is modulo 2^PC_W, so 0xFF+1 → 0x00 at PC_W=8.
- HLT: P_COUNT holds, both WEN 0, every subsequent cycle.
- REG_WEN=1 only for register-writing ops. RAM_WEN=1 only for ST. Each strobe is a single registered pulse per completed instruction. REG_IN and RAM_IN hold their last value when not written.
- MUL state machine: IDLE → MUL → IDLE.
  - IDLE with MUL: latch A and B, clear the accumulator, cnt=DATA_W, BUSY=1, both WEN 0, PC holds.
  - MUL: each edge runs one shift-add step (LSB-first) and decrements cnt. OP_CODE is ignored.
  - On the edge where cnt reaches 0: REG_IN=product, REG_WEN=1, PC+1, BUSY=0, return to IDLE.

## Timing
- All outputs are registered on rising CLK_EX.
- RESET_N=0 immediately, without a clock, forces: P_COUNT=0, REG_IN=0, RAM_IN=0, REG_WEN=0, RAM_WEN=0, FLAGS=0, BUSY=0, state=IDLE.
- Single-cycle ops: results visible one edge after the opcode is presented.
- MUL: BUSY rises on the accept edge and stays high for DATA_W edges. The result and REG_WEN appear on edge DATA_W+1 counted from accept, in the same edge BUSY falls. A new opcode is accepted on the next edge.
- Reset mid-MUL aborts the operation: no REG_WEN pulse, BUSY=0 immediately.
- Flags written by an instruction are visible to a jump on the following edge.

## Configuration
- EXEC_MUL_EN defined: MUL state machine and BUSY logic are compiled in.
- EXEC_MUL_EN undefined: 0x10 decodes as NOP (PC+1, no writes), BUSY is tied to 0, and no multiplier logic is generated.

## Test plan
- Pulse RESET_N low mid-cycle after PC=0x05 → all outputs 0 before the next CLK_EX edge.
- ADD A=0xFFFF, B=0x0001 → REG_IN=0x0000, REG_WEN=1, FLAGS={0,1,1}, PC 0→1.
- CMP A=5, B=7 then JC OP_DATA=0x40 → PC=0x40. CMP 5,5 then JNE 0x20 → PC=prev+1.
- MUL 0x0123×0x0010 (EXEC_MUL_EN) → BUSY high 16 edges, REG_IN=0x1230 on edge 17, PC+1 once.
- MUL started, RESET_N low after 5 edges → BUSY=0, PC=0, no REG_WEN pulse. Without EXEC_MUL_EN, MUL → PC+1 and BUSY stays 0.
- PC=0xFF, OR → PC=0x00. HLT → PC holds for 10 edges with both WEN 0.
